ksa_sub_pipe: RTL and testbench

KSA_SUB_PIPE -- requirements
Module: ksa_sub_pipe

---
 rtl/ksa_sub_pipe_pkg.sv | 11 +
 rtl/ksa_prefix_row.sv | 22 ++
 rtl/ksa_sub_pipe.sv | 108 ++++++++++
 tb/tb_ksa_sub_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ksa_sub_pipe_pkg.sv
// Shared definitions for the pipelined Kogge-Stone subtractor.
// Holds the default width, the prefix level count and the per-bit generate/propagate pair.
package ksa_sub_pipe_pkg;
  localparam int W_DEF = 8;
  localparam int LVL   = $clog2(W_DEF);

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;
endpackage

// File: rtl/ksa_prefix_row.sv
// One Kogge-Stone prefix level.
// Bits at or above D merge with the bit D places below them; lower bits pass through unchanged.
module ksa_prefix_row
  import ksa_sub_pipe_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int D = 1
) (
  input  pg_t [W-1:0] pg,
  output pg_t [W-1:0] pg_nxt
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    if (i >= D) begin : g_merge
      assign pg_nxt[i].g = pg[i].g | (pg[i].p & pg[i-D].g);
      assign pg_nxt[i].p = pg[i].p & pg[i-D].p;
    end else begin : g_pass
      assign pg_nxt[i] = pg[i];
    end
  end

endmodule

// File: rtl/ksa_sub_pipe.sv
// Two-stage pipelined a - b using a Kogge-Stone carry network with carry-in 1.
// Stage 1 holds p and prefix level 1; stage 2 holds diff/borrow/zero after the remaining levels.
module ksa_sub_pipe
  import ksa_sub_pipe_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         borrow,
  output logic         zero
);

  localparam int NLVL = $clog2(W);

  pg_t  [W-1:0] pg0;
  pg_t  [W-1:0] pg1;
  logic [W-1:0] p_raw;

  logic         s1_valid;
  logic [W-1:0] s1_p;
  pg_t  [W-1:0] s1_pg;

  logic         s2_adv;
  logic [W-1:0] carry;
  logic [W-1:0] diff_c;
  logic         borrow_c;
  logic         zero_c;
  logic         unused_p;

  // Carry-in of 1 is folded into bit 0's generate.
  always_comb begin
    p_raw = a ^ ~b;
    for (int i = 0; i < W; i++) begin
      pg0[i].p = p_raw[i];
      pg0[i].g = a[i] & ~b[i];
    end
    pg0[0].g = (a[0] & ~b[0]) | p_raw[0];
  end

  ksa_prefix_row #(.W(W), .D(1)) u_lvl1 (
    .pg     (pg0),
    .pg_nxt (pg1)
  );

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_pg    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_p  <= p_raw;
        s1_pg <= pg1;
      end
    end
  end

  pg_t [W-1:0] lvl [1:NLVL];
  assign lvl[1] = s1_pg;

  for (genvar k = 2; k <= NLVL; k++) begin : g_lvl
    ksa_prefix_row #(.W(W), .D(1 << (k - 1))) u_row (
      .pg     (lvl[k-1]),
      .pg_nxt (lvl[k])
    );
  end

  always_comb begin
    carry    = '0;
    unused_p = 1'b0;
    for (int i = 0; i < W; i++) begin
      carry[i] = lvl[NLVL][i].g;
      unused_p = unused_p ^ lvl[NLVL][i].p;
    end
    diff_c    = s1_p ^ {carry[W-2:0], 1'b1};
    borrow_c  = ~carry[W-1];
    zero_c    = ~|diff_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        diff   <= diff_c;
        borrow <= borrow_c;
        zero   <= zero_c;
      end
    end
  end

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Self-checking bench for ksa_sub_pipe: directed cases, backpressure, mid-op reset and a random soak.
// Expected results are queued at input accept and compared when the DUT releases a result.
module tb_ksa_sub_pipe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       borrow;
  logic       zero;

  typedef struct {
    logic [7:0] d;
    logic       br;
    logic       z;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic       held = 1'b0;
  logic [9:0] held_val;

  always #5 clk = ~clk;

  ksa_sub_pipe #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e.d  = 8'(x - y);
    e.br = (x < y);
    e.z  = (x == y);
    return e;
  endfunction

  function automatic exp_t lit(input logic [7:0] d, input logic br, input logic z);
    exp_t e;
    e.d  = d;
    e.br = br;
    e.z  = z;
    return e;
  endfunction

  // One clock: observe handshakes mid-cycle, then step past the rising edge.
  task automatic tick(input exp_t e, output bit acc);
    exp_t got;
    @(negedge clk);
    acc = rst_n && in_valid && in_ready;
    if (held) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'({diff, borrow, zero}), 32'(held_val));
    end
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        got = q.pop_front();
        chk("diff", 32'(diff), 32'(got.d));
        chk("borrow", 32'(borrow), 32'(got.br));
        chk("zero", 32'(zero), 32'(got.z));
      end
    end
    held     = rst_n && out_valid && !out_ready;
    held_val = {diff, borrow, zero};
    if (acc) q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) tick(lit(0, 0, 0), acc);
    chk("drain_left", 32'(q.size()), 32'd0);
  endtask

  initial begin
    bit   acc;
    int   naccept;
    exp_t bp_exp [3];
    logic [7:0] bp_a [3];
    logic [7:0] bp_b [3];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    tick(lit(0, 0, 0), acc);
    tick(lit(0, 0, 0), acc);
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: result visible after the second edge.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 8'h05;
    b = 8'h03;
    tick(lit(8'h02, 0, 0), acc);
    chk("lat_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    chk("lat_edge1_valid", 32'(out_valid), 32'd0);
    tick(lit(0, 0, 0), acc);
    chk("lat_edge2_valid", 32'(out_valid), 32'd1);
    chk("lat_edge2_diff", 32'(diff), 32'h02);
    drain();

    // Back-to-back directed cases, full throughput.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 8'h03; b = 8'h05; tick(lit(8'hFE, 1, 0), acc); chk("tp_acc0", 32'(acc), 32'd1);
    a = 8'h80; b = 8'h80; tick(lit(8'h00, 0, 1), acc); chk("tp_acc1", 32'(acc), 32'd1);
    a = 8'h00; b = 8'hFF; tick(lit(8'h01, 1, 0), acc); chk("tp_acc2", 32'(acc), 32'd1);
    a = 8'hFF; b = 8'h00; tick(lit(8'hFF, 0, 0), acc); chk("tp_acc3", 32'(acc), 32'd1);
    drain();

    // Backpressure: three pairs against a stalled sink.
    bp_a = '{8'h10, 8'h20, 8'h30};
    bp_b = '{8'h01, 8'h02, 8'h03};
    bp_exp[0] = lit(8'h0F, 0, 0);
    bp_exp[1] = lit(8'h1E, 0, 0);
    bp_exp[2] = lit(8'h2D, 0, 0);
    out_ready = 1'b0;
    naccept   = 0;
    for (int i = 0; i < 10 && naccept < 2; i++) begin
      in_valid = 1'b1;
      a = bp_a[naccept];
      b = bp_b[naccept];
      tick(bp_exp[naccept], acc);
      if (acc) naccept++;
    end
    chk("bp_two_accepted", 32'(naccept), 32'd2);
    a = bp_a[2];
    b = bp_b[2];
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    tick(bp_exp[2], acc);
    chk("bp_third_blocked", 32'(acc), 32'd0);
    tick(bp_exp[2], acc);
    chk("bp_third_blocked2", 32'(acc), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && !acc; i++) tick(bp_exp[2], acc);
    chk("bp_third_accepted", 32'(acc), 32'd1);
    drain();

    // Reset with two results in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 8'h44; b = 8'h11; tick(model(8'h44, 8'h11), acc);
    a = 8'h55; b = 8'h22; tick(model(8'h55, 8'h22), acc);
    in_valid = 1'b0;
    chk("mid_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick(lit(0, 0, 0), acc);
    rst_n = 1'b1;
    q.delete();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_diff", 32'(diff), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick(lit(0, 0, 0), acc);
    chk("mid_no_stale", 32'(out_valid), 32'd0);

    // Random soak; a/b held while the pair waits to be accepted.
    acc = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = 8'($urandom);
        b = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick(model(a, b), acc);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
